// File: rtl/asymmetric_bram_fwd_if.sv
// Write/read port bundle for asymmetric_bram_fwd; master drives requests, slave is the RAM.
interface asymmetric_bram_fwd_if #(
   parameter int WADDR_WIDTH = 9,
   parameter int WDATA_WIDTH = 64,
   parameter int RADDR_WIDTH = 11,
   parameter int RDATA_WIDTH = 16
);
   localparam int WLANES = (WDATA_WIDTH > RDATA_WIDTH) ? WDATA_WIDTH / RDATA_WIDTH : 1;

   logic                   WEN;
   logic [WADDR_WIDTH-1:0] WADDR;
   logic [WDATA_WIDTH-1:0] WDATA;
   logic [WLANES-1:0]      WBE;
   logic                   REN;
   logic [RADDR_WIDTH-1:0] RADDR;
   logic [RDATA_WIDTH-1:0] RDATA;
   logic                   RVALID;

   modport master (output WEN, WADDR, WDATA, WBE, REN, RADDR, input RDATA, RVALID);
   modport slave  (input WEN, WADDR, WDATA, WBE, REN, RADDR, output RDATA, RVALID);
endinterface

// File: rtl/asymmetric_bram_fwd.sv
// Single-clock asymmetric RAM: one write port and one read port of different power-of-two widths.
// Define ASYMMETRIC_BRAM_FWD_EN to forward same-cycle and in-flight write data into read results.
module asymmetric_bram_fwd #(
   parameter int WADDR_WIDTH = 9,
   parameter int WDATA_WIDTH = 64,
   parameter int RADDR_WIDTH = 11,
   parameter int RDATA_WIDTH = 16,
   parameter int MEMSIZE     = 2048,
   parameter int PIPELINED   = 0
) (
   input logic                  CLK,
   input logic                  RST_N,
   asymmetric_bram_fwd_if.slave bus
);
   localparam bit WWIDE   = WDATA_WIDTH > RDATA_WIDTH;
   localparam bit USE_WBE = WDATA_WIDTH >= RDATA_WIDTH;
   localparam int N       = WWIDE ? RDATA_WIDTH : WDATA_WIDTH;
   localparam int WIDE    = WWIDE ? WDATA_WIDTH : RDATA_WIDTH;
   localparam int R       = WIDE / N;
   localparam int WL      = WWIDE ? R : 1;
   localparam int RL      = WWIDE ? 1 : R;
   localparam int STAGES  = (PIPELINED != 0) ? 2 : 1;
   localparam int MAW     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
   localparam int IW      = 32;
`ifdef ASYMMETRIC_BRAM_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef logic [WL-1:0][N-1:0] wlanes_t;
   typedef logic [RL-1:0][N-1:0] rlanes_t;

   if ((WIDE % N) != 0 || (R & (R - 1)) != 0) begin : g_bad_ratio
      $error("asymmetric_bram_fwd: width ratio %0d/%0d is not a power of two", WIDE, N);
   end

   // Storage is kept in narrow words; the wide port touches R consecutive words.
   logic [N-1:0] mem [MEMSIZE];

   wlanes_t       wdat;
   logic [WL-1:0] wlane_we;
   logic [IW-1:0] wbase;

   always_comb begin
      wdat     = wlanes_t'(bus.WDATA);
      wbase    = IW'(bus.WADDR) * IW'(WL);
      wlane_we = '0;
      for (int k = 0; k < WL; k++)
         wlane_we[k] = RST_N && bus.WEN && (wbase + IW'(WL) <= IW'(MEMSIZE)) &&
                       (USE_WBE ? bus.WBE[k] : 1'b1);
   end

   always_ff @(posedge CLK) begin
      for (int k = 0; k < WL; k++)
         if (wlane_we[k]) mem[MAW'(wbase + IW'(k))] <= wdat[k];
   end

   // Replace read lanes that the write currently on the port is about to overwrite.
   function automatic rlanes_t fwd_merge(input rlanes_t rd, input logic [IW-1:0] rbase,
                                         input logic rok, input logic [WL-1:0] we,
                                         input logic [IW-1:0] wb, input wlanes_t wd);
      rlanes_t res;
      res = rd;
      for (int j = 0; j < RL; j++)
         for (int k = 0; k < WL; k++)
            if (FWD && rok && we[k] && (wb + IW'(k) == rbase + IW'(j))) res[j] = wd[k];
      return res;
   endfunction

   logic          racc;
   logic          rok;
   logic [IW-1:0] rbase;
   rlanes_t       rraw;
   rlanes_t       rfwd;

   always_comb begin
      racc  = RST_N && bus.REN;
      rbase = IW'(bus.RADDR) * IW'(RL);
      rok   = (rbase + IW'(RL) <= IW'(MEMSIZE));
      rraw  = '0;
      for (int j = 0; j < RL; j++)
         if (rok) rraw[j] = mem[MAW'(rbase + IW'(j))];
      rfwd  = fwd_merge(rraw, rbase, rok, wlane_we, wbase, wdat);
   end

   logic [STAGES:1] vld_pipe_d;
   logic [STAGES:1] vld_pipe_q;
   rlanes_t         rdata_d;
   rlanes_t         rdata_q;
   rlanes_t         deliver;

   if (PIPELINED != 0) begin : g_pipe
      rlanes_t       s1_dat_d, s1_dat_q;
      logic [IW-1:0] s1_base_d, s1_base_q;
      logic          s1_ok_d, s1_ok_q;

      always_comb begin
         s1_dat_d  = racc ? rfwd  : s1_dat_q;
         s1_base_d = racc ? rbase : s1_base_q;
         s1_ok_d   = racc ? rok   : s1_ok_q;
      end

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            s1_dat_q  <= '0;
            s1_base_q <= '0;
            s1_ok_q   <= 1'b0;
         end else begin
            s1_dat_q  <= s1_dat_d;
            s1_base_q <= s1_base_d;
            s1_ok_q   <= s1_ok_d;
         end
      end

      // A write landing while the read sits in stage 1 is folded in on the way out.
      assign deliver = fwd_merge(s1_dat_q, s1_base_q, s1_ok_q, wlane_we, wbase, wdat);
   end else begin : g_flow
      assign deliver = rfwd;
   end

   always_comb begin
      vld_pipe_d    = '0;
      vld_pipe_d[1] = racc;
      for (int s = 2; s <= STAGES; s++) vld_pipe_d[s] = vld_pipe_q[s-1];
      rdata_d = vld_pipe_d[STAGES] ? deliver : rdata_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vld_pipe_q <= '0;
         rdata_q    <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.RDATA  = RDATA_WIDTH'(rdata_q);
   assign bus.RVALID = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_asymmetric_bram_fwd.sv
// Scoreboard bench: 64->16 flow-through RAM and 16->64 pipelined RAM (64 narrow words) run side by side.
module tb_asymmetric_bram_fwd;
`ifdef ASYMMETRIC_BRAM_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int MSB = 64;

   logic CLK   = 1'b0;
   logic RST_N = 1'b1;
   always #5 CLK = ~CLK;

   asymmetric_bram_fwd_if #(.WADDR_WIDTH(9), .WDATA_WIDTH(64), .RADDR_WIDTH(11), .RDATA_WIDTH(16)) ia ();
   asymmetric_bram_fwd_if #(.WADDR_WIDTH(11), .WDATA_WIDTH(16), .RADDR_WIDTH(9), .RDATA_WIDTH(64)) ib ();

   asymmetric_bram_fwd #(.WADDR_WIDTH(9), .WDATA_WIDTH(64), .RADDR_WIDTH(11), .RDATA_WIDTH(16),
                         .MEMSIZE(2048), .PIPELINED(0))
      dut_a (.CLK(CLK), .RST_N(RST_N), .bus(ia.slave));
   asymmetric_bram_fwd #(.WADDR_WIDTH(11), .WDATA_WIDTH(16), .RADDR_WIDTH(9), .RDATA_WIDTH(64),
                         .MEMSIZE(MSB), .PIPELINED(1))
      dut_b (.CLK(CLK), .RST_N(RST_N), .bus(ib.slave));

   typedef struct { logic [63:0] data; int due; } exp_t;
   typedef struct { logic wen; logic [10:0] waddr; logic [63:0] wdata; logic [3:0] wbe;
                    logic ren; logic [10:0] raddr; logic kv; logic [63:0] k; } op_t;

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [15:0] ma [2048];
   logic [15:0] mb [MSB];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        pend_v = 1'b0;
   logic [10:0] pend_addr;
   int          pend_due;
   logic        pend_kv;
   logic [63:0] pend_k;
   logic [15:0] last_a = '0;
   logic [63:0] last_b = '0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: flat array of 16-bit words per RAM.
   function automatic logic [15:0] rd_a(input logic [10:0] ra);
      return ma[ra];
   endfunction

   function automatic logic [63:0] rd_b(input logic [10:0] ra);
      logic [63:0] v;
      v = '0;
      if (int'(ra) * 4 + 3 < MSB)
         for (int j = 0; j < 4; j++) v[j*16 +: 16] = mb[int'(ra) * 4 + j];
      return v;
   endfunction

   task automatic wr_a(input logic [8:0] wa, input logic [63:0] wd, input logic [3:0] be);
      for (int k = 0; k < 4; k++) if (be[k]) ma[int'(wa) * 4 + k] = wd[k*16 +: 16];
   endtask

   task automatic wr_b(input logic [10:0] wa, input logic [15:0] wd);
      if (int'(wa) < MSB) mb[wa] = wd;
   endtask

   task automatic drive_idle();
      ia.WEN = 0; ia.WADDR = '0; ia.WDATA = '0; ia.WBE = '0; ia.REN = 0; ia.RADDR = '0;
      ib.WEN = 0; ib.WADDR = '0; ib.WDATA = '0; ib.WBE = '0; ib.REN = 0; ib.RADDR = '0;
   endtask

   // One cycle of stimulus on both RAMs; expected results are queued from the model.
   task automatic step(input op_t a, input op_t b);
      logic [15:0] a_old;
      logic [63:0] b_old;
      @(negedge CLK);
      ia.WEN = a.wen; ia.WADDR = a.waddr[8:0]; ia.WDATA = a.wdata; ia.WBE = a.wbe;
      ia.REN = a.ren; ia.RADDR = a.raddr;
      ib.WEN = b.wen; ib.WADDR = b.waddr; ib.WDATA = b.wdata[15:0]; ib.WBE = b.wbe[0];
      ib.REN = b.ren; ib.RADDR = b.raddr[8:0];
      a_old = rd_a(a.raddr);
      if (a.wen) wr_a(a.waddr[8:0], a.wdata, a.wbe);
      if (a.ren) q_a.push_back('{data: a.kv ? a.k : 64'(FWD ? rd_a(a.raddr) : a_old), due: cyc + 1});
      b_old = rd_b({2'b00, b.raddr[8:0]});
      if (b.wen) wr_b(b.waddr, b.wdata[15:0]);
      if (pend_v) begin
         q_b.push_back('{data: pend_kv ? pend_k : rd_b(pend_addr), due: pend_due});
         pend_v = 1'b0;
      end
      if (b.ren) begin
         if (FWD) begin
            pend_v = 1'b1; pend_addr = {2'b00, b.raddr[8:0]}; pend_due = cyc + 2;
            pend_kv = b.kv; pend_k = b.k;
         end else begin
            q_b.push_back('{data: b.kv ? b.k : b_old, due: cyc + 2});
         end
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (!RST_N) begin
            chk("a_rst_rvalid", 64'(ia.RVALID), 64'd0);
            chk("a_rst_rdata", 64'(ia.RDATA), 64'd0);
            chk("b_rst_rvalid", 64'(ib.RVALID), 64'd0);
            chk("b_rst_rdata", ib.RDATA, 64'd0);
            last_a = '0;
            last_b = '0;
         end else begin
            if (ia.RVALID) begin
               if (q_a.size() == 0) chk("a_unexpected_rvalid", 64'(ia.RVALID), 64'd0);
               else begin
                  e = q_a.pop_front();
                  chk("a_rdata", 64'(ia.RDATA), 64'(e.data[15:0]));
                  chk("a_latency", 64'(cyc), 64'(e.due));
               end
               last_a = ia.RDATA;
            end else chk("a_hold", 64'(ia.RDATA), 64'(last_a));
            if (ib.RVALID) begin
               if (q_b.size() == 0) chk("b_unexpected_rvalid", 64'(ib.RVALID), 64'd0);
               else begin
                  e = q_b.pop_front();
                  chk("b_rdata", ib.RDATA, e.data);
                  chk("b_latency", 64'(cyc), 64'(e.due));
               end
               last_b = ib.RDATA;
            end else chk("b_hold", ib.RDATA, last_b);
         end
      end
   end

   initial begin : main
      op_t a, b, nop;
      nop = '{default: '0};
      drive_idle();
      #1 RST_N = 1'b0;
      #2;
      chk("a_reset_rvalid", 64'(ia.RVALID), 64'd0);
      chk("a_reset_rdata", 64'(ia.RDATA), 64'd0);
      chk("b_reset_rvalid", 64'(ib.RVALID), 64'd0);
      chk("b_reset_rdata", ib.RDATA, 64'd0);
      repeat (3) @(posedge CLK);
      #2 RST_N = 1'b1;

      // Fill both memories; B addresses past 63 must be dropped.
      for (int i = 0; i < 512; i++) begin
         a = nop; b = nop;
         a.wen = 1; a.waddr = 11'(i); a.wdata = {$urandom, $urandom}; a.wbe = 4'hF;
         b.wen = 1; b.waddr = 11'(i); b.wdata = 64'($urandom_range(0, 65535));
         step(a, b);
      end

      a = nop; a.wen = 1; a.waddr = 3; a.wdata = 64'h4444_3333_2222_1111; a.wbe = 4'hF;
      step(a, nop);
      for (int i = 0; i < 4; i++) begin
         a = nop; a.ren = 1; a.raddr = 11'(12 + i); a.kv = 1;
         a.k = 64'(16'h1111 * (i + 1));
         step(a, nop);
      end
      a = nop; a.wen = 1; a.waddr = 3; a.wdata = 64'hAAAA_BBBB_CCCC_DDDD; a.wbe = 4'b0100;
      step(a, nop);
      a = nop; a.ren = 1; a.raddr = 14; a.kv = 1; a.k = 64'hBBBB; step(a, nop);
      a = nop; a.ren = 1; a.raddr = 13; a.kv = 1; a.k = 64'h2222; step(a, nop);
      a = nop; a.wen = 1; a.waddr = 5; a.wdata = 64'h0000_0000_0000_0001; a.wbe = 4'b0001;
      step(a, nop);
      a = nop; a.wen = 1; a.waddr = 5; a.wdata = 64'h9999_8888_7777_0007; a.wbe = 4'b0001;
      a.ren = 1; a.raddr = 20; a.kv = 1; a.k = FWD ? 64'h0007 : 64'h0001;
      step(a, nop);

      for (int i = 0; i < 4; i++) begin
         b = nop; b.wen = 1; b.waddr = 11'(8 + i); b.wdata = 64'(i + 1);
         step(nop, b);
      end
      b = nop; b.ren = 1; b.raddr = 2; b.kv = 1; b.k = 64'h0004_0003_0002_0001; step(nop, b);
      b = nop; b.ren = 1; b.raddr = 2; b.kv = 1;
      b.k = FWD ? 64'h0004_0003_0055_0001 : 64'h0004_0003_0002_0001;
      step(nop, b);
      b = nop; b.wen = 1; b.waddr = 9; b.wdata = 64'h55; step(nop, b);
      b = nop; b.ren = 1; b.raddr = 2; b.kv = 1; b.k = 64'h0004_0003_0055_0001; step(nop, b);

      for (int i = 0; i < 1500; i++) begin
         a = nop; b = nop;
         a.wen   = 1'($urandom_range(0, 1));
         a.waddr = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 511)) : 11'($urandom_range(0, 7));
         a.wdata = {$urandom, $urandom};
         a.wbe   = 4'($urandom);
         a.ren   = ($urandom_range(0, 3) != 0);
         a.raddr = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 31));
         b.wen   = 1'($urandom_range(0, 1));
         b.waddr = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(64, 2047)) : 11'($urandom_range(0, 63));
         b.wdata = 64'($urandom_range(0, 65535));
         b.ren   = ($urandom_range(0, 3) != 0);
         b.raddr = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(16, 511)) : 11'($urandom_range(0, 15));
         step(a, b);
      end

      // Reset with a pipelined read in flight, then confirm contents survive.
      a = nop; a.ren = 1; a.raddr = 12; b = nop; b.ren = 1; b.raddr = 2;
      step(a, b);
      repeat (3) step(nop, nop);
      b = nop; b.ren = 1; b.raddr = 2;
      step(nop, b);
      @(negedge CLK);
      drive_idle();
      RST_N = 1'b0;
      #1;
      chk("b_rst_imm_rvalid", 64'(ib.RVALID), 64'd0);
      chk("b_rst_imm_rdata", ib.RDATA, 64'd0);
      chk("a_rst_imm_rdata", 64'(ia.RDATA), 64'd0);
      chk("a_drained_at_reset", 64'(q_a.size()), 64'd0);
      pend_v = 1'b0;
      q_b.delete();
      repeat (3) begin
         @(negedge CLK);
         ia.WEN = 1; ia.WADDR = 9'($urandom_range(0, 7)); ia.WDATA = {$urandom, $urandom};
         ia.WBE = 4'hF; ia.REN = 1; ia.RADDR = 11'($urandom_range(0, 31));
         ib.WEN = 1; ib.WADDR = 11'($urandom_range(8, 11)); ib.WDATA = 16'($urandom);
         ib.REN = 1; ib.RADDR = 9'd2;
      end
      @(negedge CLK);
      drive_idle();
      @(posedge CLK);
      #2 RST_N = 1'b1;

      a = nop; a.ren = 1; a.raddr = 12; b = nop; b.ren = 1; b.raddr = 2;
      step(a, b);
      for (int i = 0; i < 200; i++) begin
         a = nop; b = nop;
         a.wen = ($urandom_range(0, 3) == 0); a.waddr = 11'($urandom_range(0, 7));
         a.wdata = {$urandom, $urandom}; a.wbe = 4'($urandom);
         a.ren = 1; a.raddr = 11'($urandom_range(0, 31));
         b.wen = ($urandom_range(0, 3) == 0); b.waddr = 11'($urandom_range(0, 63));
         b.wdata = 64'($urandom_range(0, 65535));
         b.ren = 1'($urandom_range(0, 1)); b.raddr = 11'($urandom_range(0, 15));
         step(a, b);
      end
      repeat (4) step(nop, nop);
      @(negedge CLK);
      chk("a_queue_empty", 64'(q_a.size()), 64'd0);
      chk("b_queue_empty", 64'(q_b.size()), 64'd0);
      chk("b_pending_empty", 64'(pend_v), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/asymmetric_bram_fwd.md
ASYMMETRIC_BRAM_FWD -- requirements
Module: asymmetric_bram_fwd

Interface
REQ-001 SHALL have parameter WADDR_WIDTH, default 9, write-port address width.
REQ-002 SHALL have parameter WDATA_WIDTH, default 64, write-port data width.
REQ-003 SHALL have parameter RADDR_WIDTH, default 11, read-port address width.
REQ-004 SHALL have parameter RDATA_WIDTH, default 16, read-port data width.
REQ-005 SHALL have parameter MEMSIZE, default 2048, capacity in words of the narrower port.
REQ-006 SHALL have parameter PIPELINED, default 0; 1 adds an output register stage.
REQ-007 SHALL have port CLK input 1, sole clock, all state on rising edge.
REQ-008 SHALL have port RST_N input 1, asynchronous active-low reset.
REQ-009 SHALL have port WEN input 1, write enable.
REQ-010 SHALL have port WADDR input WADDR_WIDTH, write address in write-port words.
REQ-011 SHALL have port WDATA input WDATA_WIDTH, write data.
REQ-012 SHALL have port WBE input WLANES, per-lane write enable; WLANES = WDATA_WIDTH/RDATA_WIDTH when write is wider, else 1.
REQ-013 SHALL have port REN input 1, read request.
REQ-014 SHALL have port RADDR input RADDR_WIDTH, read address in read-port words.
REQ-015 SHALL have port RDATA output RDATA_WIDTH, read data.
REQ-016 SHALL have port RVALID output 1, RDATA carries the result of a REN request this cycle.

Function
REQ-017 SHALL support both wide-write/narrow-read and narrow-write/wide-read; ratio R = wider/narrower SHALL be a power of two (including 1); otherwise elaboration SHALL fail.
REQ-018 SHALL map lanes little-endian: narrow index = wide_addr*R + k, lane k at wide bits [k*N +: N], N = narrower width.
REQ-019 SHALL write only lanes with WBE[k]=1 when WEN=1; WBE ignored when write port is narrower.
REQ-020 SHALL register a read on REN=1; RDATA/RVALID valid 1 cycle later (PIPELINED=0) or 2 cycles later (PIPELINED=1); back-to-back reads every cycle SHALL be accepted.
REQ-021 SHALL hold RDATA at its last valid value while no result is delivered; RVALID SHALL pulse exactly once per accepted REN.
REQ-022 SHALL drop writes whose narrow index range exceeds MEMSIZE-1; reads beyond range SHALL return 0 with RVALID=1.
REQ-023 SHALL, for WEN and REN same cycle with no lane overlap, perform both independently.
REQ-024 SHALL resolve same-cycle overlapping read/write per REQ-031 per narrow lane; non-overlapping lanes of a wide read SHALL return stored data.
REQ-025 SHALL implement storage as inferred registered RAM, no vendor primitive; contents not initialised.

Reset
REQ-026 SHALL, on RST_N=0, force RVALID=0 and RDATA=0 immediately, independent of CLK.
REQ-027 SHALL discard any read in flight at reset assertion; no RVALID for it after release.
REQ-028 SHALL ignore WEN and REN while RST_N=0; memory contents SHALL NOT be cleared.
REQ-029 SHALL accept requests on the first rising CLK edge after RST_N deasserts.

Configuration
REQ-030 SHALL compile write-to-read forwarding under macro ASYMMETRIC_BRAM_FWD_EN.
REQ-031 SHALL with ASYMMETRIC_BRAM_FWD_EN defined return newly written lane data for same-cycle overlapping lanes and for a write in the cycle between read acceptance and delivery when PIPELINED=1; without it SHALL return old (pre-write) lane data.

Verification
REQ-032 Defaults: write WADDR=3, WDATA=0x4444_3333_2222_1111, WBE=4'hF; read RADDR=12..15 back-to-back -> RDATA 0x1111,0x2222,0x3333,0x4444, RVALID 4 consecutive cycles at latency 1.
REQ-033 WBE=4'b0100 write WDATA=0xAAAA_BBBB_CCCC_DDDD to WADDR=3 after REQ-032 -> RADDR=14 reads 0xBBBB, RADDR=13 still 0x2222.
REQ-034 Same-cycle WEN WADDR=5 WDATA=0x…0007 lane0 and REN RADDR=20 over old 0x0001 -> RDATA 0x0007 with FWD_EN, 0x0001 without.
REQ-035 Narrow-write config (W=16, R=64): write 0x1,0x2,0x3,0x4 to 8..11, read RADDR=2 with PIPELINED=1 -> RDATA 0x0004_0003_0002_0001 two cycles after REN.
REQ-036 Assert RST_N=0 cycle after REN (PIPELINED=1) -> RVALID, RDATA 0 immediately; no RVALID after release; prior memory contents readable unchanged.
